// File: rtl/pattern_bank_array.sv
// pattern_bank_array: NO_BUFS banks of BUF_SIZE x BUF_WIDTH pattern storage.
// Each bank is loadable through its own serial scan chain or by random-access
// field writes, and can be read back one field at a time through a register.
// A small swap FSM selects which bank is "active"; the active bank is copied
// every cycle into current_buffer for the pattern sequencer.
//
// Handshake: sel_req is sampled only while sel_busy is low. An accepted request
// raises sel_busy until the swap is committed; the cycle after the commit edge
// sel_ack pulses high for exactly one cycle, and by then current_buffer already
// holds the new bank. A request naming a bank that does not exist is rejected
// with a one-cycle sel_err pulse and never raises sel_busy.
module pattern_bank_array #(
  parameter int NO_BUFS   = 8,
  parameter int BUF_SIZE  = 22,
  parameter int BUF_WIDTH = 8,
  parameter int AW        = $clog2(BUF_SIZE),
  parameter int BW        = $clog2(NO_BUFS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shift_en,
  input  logic                          sin,
  input  logic [BW-1:0]                 saddr,
  output logic                          sout,
  input  logic                          wr_en,
  input  logic [BW-1:0]                 wr_bank,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [BUF_WIDTH-1:0]          wr_data,
  output logic                          wr_err,
  input  logic [BW-1:0]                 rd_bank,
  input  logic [AW-1:0]                 rd_addr,
  output logic [BUF_WIDTH-1:0]          rd_data,
  input  logic                          sel_req,
  input  logic [BW-1:0]                 sel_idx,
  output logic                          sel_busy,
  output logic                          sel_ack,
  output logic                          sel_err,
  output logic [BW-1:0]                 active_bank,
  output logic [BUF_SIZE*BUF_WIDTH-1:0] current_buffer
);

  localparam int N = BUF_SIZE * BUF_WIDTH;

  // Range limits one bit wider than the indices so the compare is never
  // trivially true/false for power-of-two sizes.
  localparam logic [BW:0] NB_LIM = (BW+1)'(NO_BUFS);
  localparam logic [AW:0] NS_LIM = (AW+1)'(BUF_SIZE);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Bank b holds entry e at bank_q[b][e*BUF_WIDTH +: BUF_WIDTH]; the serial
  // chain is the whole vector with entry BUF_SIZE-1 at the MSB end.
  logic [N-1:0]         bank_q [NO_BUFS];
  logic [1:0]           state;
  logic [BW-1:0]        pend_idx;

  logic                 shift_ok;
  logic                 wr_ok;
  logic                 rd_addr_ok;
  logic                 sel_ok;
  logic                 sel_hit_shift;
  logic                 pend_hit_shift;
  logic [BW-1:0]        mirror_idx;
  logic [N-1:0]         shift_vec;
  logic [N-1:0]         rd_vec;
  logic [N-1:0]         mirror_vec;
  logic [BUF_WIDTH-1:0] rd_word;

  // Request qualification: range checks and shift/write/swap collisions.
  always_comb begin
    shift_ok       = shift_en && ({1'b0, saddr} < NB_LIM);
    wr_ok          = wr_en && ({1'b0, wr_bank} < NB_LIM) && ({1'b0, wr_addr} < NS_LIM)
                     && !(shift_ok && (saddr == wr_bank));
    rd_addr_ok     = ({1'b0, rd_addr} < NS_LIM);
    sel_ok         = ({1'b0, sel_idx} < NB_LIM);
    sel_hit_shift  = shift_ok && (saddr == sel_idx);
    pend_hit_shift = shift_ok && (saddr == pend_idx);
    // During COMMIT the mirror already follows the bank being switched to.
    mirror_idx     = (state == S_COMMIT) ? pend_idx : active_bank;
  end

  // Bank selection muxes; an index with no matching bank selects all zeros.
  always_comb begin
    shift_vec  = '0;
    rd_vec     = '0;
    mirror_vec = '0;
    for (int b = 0; b < NO_BUFS; b++) begin
      if (saddr == BW'(b))      shift_vec  = bank_q[b];
      if (rd_bank == BW'(b))    rd_vec     = bank_q[b];
      if (mirror_idx == BW'(b)) mirror_vec = bank_q[b];
    end
    rd_word = '0;
    if (rd_addr_ok) rd_word = rd_vec[rd_addr*BUF_WIDTH +: BUF_WIDTH];
  end

  assign sout     = shift_vec[N-1];
  assign sel_busy = (state != S_IDLE);

  // Storage: serial shift wins over a field write to the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NO_BUFS; b++) bank_q[b] <= '0;
    end else begin
      for (int b = 0; b < NO_BUFS; b++) begin
        if (shift_ok && (saddr == BW'(b))) begin
          bank_q[b] <= {bank_q[b][N-2:0], sin};
        end else if (wr_ok && (wr_bank == BW'(b))) begin
          bank_q[b][wr_addr*BUF_WIDTH +: BUF_WIDTH] <= wr_data;
        end
      end
    end
  end

  // Registered read port, write-drop flag and active-bank mirror.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data        <= '0;
      wr_err         <= 1'b0;
      current_buffer <= '0;
    end else begin
      rd_data        <= rd_word;
      wr_err         <= wr_en && !wr_ok;
      current_buffer <= mirror_vec;
    end
  end

  // Active-bank swap FSM: waits in PEND while the requested bank is shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pend_idx    <= '0;
      active_bank <= '0;
      sel_ack     <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      sel_ack <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_req) begin
            if (!sel_ok) begin
              sel_err <= 1'b1;
            end else begin
              pend_idx <= sel_idx;
              state    <= sel_hit_shift ? S_PEND : S_COMMIT;
            end
          end
        end
        S_PEND: begin
          if (!pend_hit_shift) state <= S_COMMIT;
        end
        S_COMMIT: begin
          active_bank <= pend_idx;
          sel_ack     <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_bank_array.sv
// Bench for pattern_bank_array, built with NO_BUFS=9 (BW=4) so that both an
// existing top bank (8) and non-existent banks (9..15) are reachable.
module tb_pattern_bank_array;

  localparam int NB = 9;
  localparam int SZ = 22;
  localparam int W  = 8;
  localparam int AW = 5;
  localparam int BW = 4;
  localparam int N  = SZ * W;

  // Clock / reset and DUT signals
  logic          clk;
  logic          rst_n;
  logic          shift_en;
  logic          sin;
  logic [BW-1:0] saddr;
  logic          sout;
  logic          wr_en;
  logic [BW-1:0] wr_bank;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_err;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          sel_req;
  logic [BW-1:0] sel_idx;
  logic          sel_busy;
  logic          sel_ack;
  logic          sel_err;
  logic [BW-1:0] active_bank;
  logic [N-1:0]  current_buffer;

  pattern_bank_array #(.NO_BUFS(NB), .BUF_SIZE(SZ), .BUF_WIDTH(W)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .shift_en       (shift_en),
    .sin            (sin),
    .saddr          (saddr),
    .sout           (sout),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_err         (wr_err),
    .rd_bank        (rd_bank),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .sel_req        (sel_req),
    .sel_idx        (sel_idx),
    .sel_busy       (sel_busy),
    .sel_ack        (sel_ack),
    .sel_err        (sel_err),
    .active_bank    (active_bank),
    .current_buffer (current_buffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int           n_checks;
  int           n_fail;
  logic [W-1:0] exp_q[$];      // expected rd_data, one per issued read
  logic [2:0]   exp_ev_q[$];   // expected pulse {sel_ack, sel_err, wr_err}
  logic         rd_go;
  logic         rd_go_d;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cyc(input int b, input int a, input logic [W-1:0] e);
    rd_bank = BW'(b);
    rd_addr = AW'(a);
    rd_go   = 1'b1;
    exp_q.push_back(e);
    step();
    rd_go   = 1'b0;
  endtask

  task automatic write_cyc(input int b, input int a, input logic [W-1:0] d, input logic err);
    wr_en   = 1'b1;
    wr_bank = BW'(b);
    wr_addr = AW'(a);
    wr_data = d;
    if (err) exp_ev_q.push_back(3'b001);
    step();
    wr_en   = 1'b0;
  endtask

  // Monitor: read data one cycle after a read is issued, and every pulse.
  always @(posedge clk) rd_go_d <= rd_go;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [2:0]   ev;
    logic [2:0]   got;
    if (rd_go_d === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_data_unexpected", N'(1), N'(0));
      end else begin
        e = exp_q.pop_front();
        check("rd_data", N'(rd_data), N'(e));
      end
    end
    got = {sel_ack, sel_err, wr_err};
    if (got !== 3'b000) begin
      if (exp_ev_q.size() == 0) begin
        check("pulse_unexpected", N'(got), N'(0));
      end else begin
        ev = exp_ev_q.pop_front();
        check("pulse", N'(got), N'(ev));
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] chain_m;
    logic [W-1:0] bv;
    int           busy_cnt;

    n_checks = 0;
    n_fail   = 0;
    rd_go    = 1'b0;
    shift_en = 1'b0; sin = 1'b0; saddr = '0;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_bank = '0; rd_addr = '0;
    sel_req = 1'b0; sel_idx = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_rd_data",     N'(rd_data),     N'(0));
    check("rst_cur_buf",     current_buffer,  '0);
    check("rst_active_bank", N'(active_bank), N'(0));
    check("rst_busy",        N'(sel_busy),    N'(0));
    check("rst_pulses",      N'({sel_ack, sel_err, wr_err}), N'(0));
    check("rst_sout",        N'(sout),        N'(0));
    rst_n = 1'b1;
    step();

    // Serial load of bank 3: 0xA5 then 0x01..0x15, MSB first
    chain_m = '0;
    for (int k = 0; k < SZ; k++) begin
      bv = (k == 0) ? 8'hA5 : 8'(k);
      for (int i = W - 1; i >= 0; i--) begin
        shift_en = 1'b1;
        saddr    = 4'd3;
        sin      = bv[i];
        step();
        chain_m = {chain_m[N-2:0], bv[i]};
      end
      check("shift_sout", N'(sout), N'(chain_m[N-1]));
    end
    shift_en = 1'b0;
    sin      = 1'b0;
    read_cyc(3, 0,  8'h15);
    read_cyc(3, 10, 8'h0B);
    read_cyc(3, 20, 8'h01);
    read_cyc(3, 21, 8'hA5);
    saddr = 4'd3;  #1; check("sout_bank3",  N'(sout), N'(1));
    saddr = 4'd2;  #1; check("sout_bank2",  N'(sout), N'(0));
    saddr = 4'd12; #1; check("sout_oor",    N'(sout), N'(0));

    // Write with same-cycle read of the same entry returns old data
    wr_en = 1'b1; wr_bank = 4'd2; wr_addr = 5'd5; wr_data = 8'h3C;
    rd_bank = 4'd2; rd_addr = 5'd5; rd_go = 1'b1;
    exp_q.push_back(8'h00);
    step();
    wr_en = 1'b0;
    exp_q.push_back(8'h3C);
    step();
    rd_go = 1'b0;

    // Dropped writes: bad entry, bad bank, collision with shift
    write_cyc(4, 22, 8'hEE, 1'b1);
    write_cyc(9, 0,  8'hEE, 1'b1);
    write_cyc(15, 21, 8'hEE, 1'b1);
    shift_en = 1'b1; saddr = 4'd1; sin = 1'b0;
    write_cyc(1, 0, 8'h11, 1'b1);
    shift_en = 1'b0;
    write_cyc(8, 21, 8'h77, 1'b0);
    read_cyc(8, 21, 8'h77);
    read_cyc(4, 21, 8'h00);
    read_cyc(4, 22, 8'h00);
    read_cyc(1, 0,  8'h00);
    read_cyc(9, 0,  8'h00);
    read_cyc(0, 0,  8'h00);

    // Swap to bank 5 while bank 5 shifts ten ones
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      sel_req  = (i == 0);
      sel_idx  = 4'd5;
      shift_en = (i < 10);
      saddr    = 4'd5;
      sin      = 1'b1;
      if (i == 0) exp_ev_q.push_back(3'b100);
      step();
      if (sel_busy) busy_cnt++;
    end
    sel_req = 1'b0; shift_en = 1'b0; sin = 1'b0;
    check("pend_busy_cycles", N'(busy_cnt),    N'(11));
    check("swap5_active",     N'(active_bank), N'(5));
    check("swap5_mirror_e0",  N'(current_buffer[7:0]),   N'(8'hFF));
    check("swap5_mirror_e1",  N'(current_buffer[15:8]),  N'(8'h03));
    check("swap5_mirror_e2",  N'(current_buffer[23:16]), N'(8'h00));

    // Rejected swaps to non-existent banks
    sel_req = 1'b1; sel_idx = 4'd9;
    exp_ev_q.push_back(3'b010);
    step();
    sel_req = 1'b0;
    check("sel9_busy", N'(sel_busy), N'(0));
    step();
    sel_req = 1'b1; sel_idx = 4'd15;
    exp_ev_q.push_back(3'b010);
    step();
    sel_req = 1'b0;
    step();
    check("sel_oor_active", N'(active_bank), N'(5));

    // Mirror lags a write into the active bank by one cycle
    write_cyc(5, 3, 8'h5A, 1'b0);
    check("mirror_lag_old", N'(current_buffer[31:24]), N'(8'h00));
    step();
    check("mirror_lag_new", N'(current_buffer[31:24]), N'(8'h5A));

    // Swap to the already active bank is acknowledged, nothing changes
    sel_req = 1'b1; sel_idx = 4'd5;
    exp_ev_q.push_back(3'b100);
    step();
    sel_req = 1'b0;
    check("same_swap_busy", N'(sel_busy), N'(1));
    step();
    check("same_swap_active", N'(active_bank), N'(5));

    // Direct swap to bank 3 brings its serial pattern into the mirror
    sel_req = 1'b1; sel_idx = 4'd3;
    exp_ev_q.push_back(3'b100);
    step();
    sel_req = 1'b0;
    step();
    check("swap3_active",     N'(active_bank), N'(3));
    check("swap3_mirror_e21", N'(current_buffer[N-1 -: 8]), N'(8'hA5));
    check("swap3_mirror_e0",  N'(current_buffer[7:0]),      N'(8'h15));

    // Reset in the middle of a pending swap
    sel_req = 1'b1; sel_idx = 4'd2; shift_en = 1'b1; saddr = 4'd2; sin = 1'b1;
    step();
    sel_req = 1'b0;
    check("pend_busy", N'(sel_busy), N'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pend_active", N'(active_bank), N'(0));
    check("rst_pend_busy",   N'(sel_busy),    N'(0));
    check("rst_pend_mirror", current_buffer,  '0);
    shift_en = 1'b0; sin = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("post_rst_active", N'(active_bank), N'(0));
    check("post_rst_busy",   N'(sel_busy),    N'(0));
    read_cyc(3, 21, 8'h00);
    read_cyc(8, 21, 8'h00);

    // Drain and make sure every expected response was observed
    repeat (3) step();
    check("rd_queue_empty", N'(exp_q.size()),    N'(0));
    check("ev_queue_empty", N'(exp_ev_q.size()), N'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
